// File: rtl/game_timer_ctrl.sv
// Elapsed-time controller for the Sudoku display: BCD MM:SS counter with
// start/pause/stop sequencing and a 4-digit multiplexed 7-segment scan.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | time cleared, prescaler held at 0, waiting for start
// ST_RUN   | prescaler counting, one tick per elapsed second
// ST_PAUSE | prescaler and time frozen, fractional second retained
// ST_SAT   | time pinned at 99:59, only stop or clr leave
module game_timer_ctrl #(
   parameter int SEC_CYCLES  = 100000000,
   parameter int SCAN_CYCLES = 131072
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic       pause,
   input  logic       stop,
   output logic       sec_tick,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [3:0] an,
   output logic [3:0] digit,
   output logic       running,
   output logic       overflow
);

   localparam int PW = (SEC_CYCLES > 2) ? $clog2(SEC_CYCLES) : 1;
   localparam int SW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_TC  = PW'(SEC_CYCLES - 1);
   localparam logic [SW-1:0] SCAN_TC = SW'(SCAN_CYCLES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_SAT   = 2'd3;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [PW-1:0] pre_cnt;
   logic [PW-1:0] pre_nxt;
   logic          tick_nxt;
   logic [3:0]    mt_nxt;
   logic [3:0]    mo_nxt;
   logic [3:0]    st_nxt;
   logic [3:0]    so_nxt;
   logic          at_tc;
   logic          at_max;

   logic [SW-1:0] scan_cnt;
   logic [SW-1:0] scan_cnt_nxt;
   logic [1:0]    scan_idx;
   logic [1:0]    scan_idx_nxt;
   logic          scan_wrap;
   logic [3:0]    an_nxt;
   logic [3:0]    digit_nxt;

   assign at_tc  = (pre_cnt == PRE_TC);
   assign at_max = (min_tens == 4'd9) && (min_ones == 4'd9) &&
                   (sec_tens == 4'd5) && (sec_ones == 4'd9);

   // The terminal count always takes its tick, even with pause in the same
   // cycle; otherwise a pause freezes the prescaler on the value it had.
   always_comb begin
      state_nxt = state;
      pre_nxt   = pre_cnt;
      tick_nxt  = 1'b0;
      mt_nxt    = min_tens;
      mo_nxt    = min_ones;
      st_nxt    = sec_tens;
      so_nxt    = sec_ones;
      if (stop) begin
         state_nxt = ST_IDLE;
         pre_nxt   = '0;
         mt_nxt    = 4'd0;
         mo_nxt    = 4'd0;
         st_nxt    = 4'd0;
         so_nxt    = 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               pre_nxt = '0;
               if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
               if (at_tc) begin
                  pre_nxt  = '0;
                  tick_nxt = 1'b1;
                  if (at_max) begin
                     state_nxt = ST_SAT;
                  end else begin
                     if (pause) state_nxt = ST_PAUSE;
                     if (sec_ones == 4'd9) begin
                        so_nxt = 4'd0;
                        if (sec_tens == 4'd5) begin
                           st_nxt = 4'd0;
                           if (min_ones == 4'd9) begin
                              mo_nxt = 4'd0;
                              mt_nxt = min_tens + 4'd1;
                           end else begin
                              mo_nxt = min_ones + 4'd1;
                           end
                        end else begin
                           st_nxt = sec_tens + 4'd1;
                        end
                     end else begin
                        so_nxt = sec_ones + 4'd1;
                     end
                  end
               end else if (pause) begin
                  state_nxt = ST_PAUSE;
               end else begin
                  pre_nxt = pre_cnt + PW'(1);
               end
            end
            ST_PAUSE: begin
               if (pause) state_nxt = ST_RUN;
            end
            default: begin
               state_nxt = ST_SAT;
            end
         endcase
      end
   end

   assign scan_wrap    = (scan_cnt == SCAN_TC);
   assign scan_cnt_nxt = scan_wrap ? '0 : scan_cnt + SW'(1);
   assign scan_idx_nxt = scan_wrap ? scan_idx + 2'd1 : scan_idx;

   // an and digit come from the same index so they always agree.
   always_comb begin
      an_nxt    = 4'b1110;
      digit_nxt = sec_ones;
      case (scan_idx_nxt)
         2'd1: begin
            an_nxt    = 4'b1101;
            digit_nxt = sec_tens;
         end
         2'd2: begin
            an_nxt    = 4'b1011;
            digit_nxt = min_ones;
         end
         2'd3: begin
            an_nxt    = 4'b0111;
            digit_nxt = min_tens;
         end
         default: begin
            an_nxt    = 4'b1110;
            digit_nxt = sec_ones;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= ST_IDLE;
         pre_cnt  <= '0;
         sec_tick <= 1'b0;
         min_tens <= 4'd0;
         min_ones <= 4'd0;
         sec_tens <= 4'd0;
         sec_ones <= 4'd0;
         running  <= 1'b0;
         overflow <= 1'b0;
         scan_cnt <= '0;
         scan_idx <= 2'd0;
         an       <= 4'b1110;
         digit    <= 4'd0;
      end else begin
         state    <= state_nxt;
         pre_cnt  <= pre_nxt;
         sec_tick <= tick_nxt;
         min_tens <= mt_nxt;
         min_ones <= mo_nxt;
         sec_tens <= st_nxt;
         sec_ones <= so_nxt;
         running  <= (state_nxt == ST_RUN);
         overflow <= (state_nxt == ST_SAT);
         scan_cnt <= scan_cnt_nxt;
         scan_idx <= scan_idx_nxt;
         an       <= an_nxt;
         digit    <= digit_nxt;
      end
   end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl with a short second (10 cycles) and a
// short scan slot (4 cycles); expected values are hand-derived.
module tb_game_timer_ctrl;

   localparam int SEC  = 10;
   localparam int SCAN = 4;

   logic       clk   = 1'b0;
   logic       clr   = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       stop  = 1'b0;
   logic       sec_tick;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic [3:0] an;
   logic [3:0] digit;
   logic       running;
   logic       overflow;
   logic [15:0] tm;

   int vectors     = 0;
   int miscompares = 0;

   game_timer_ctrl #(.SEC_CYCLES(SEC), .SCAN_CYCLES(SCAN)) dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .pause    (pause),
      .stop     (stop),
      .sec_tick (sec_tick),
      .min_tens (min_tens),
      .min_ones (min_ones),
      .sec_tens (sec_tens),
      .sec_ones (sec_ones),
      .an       (an),
      .digit    (digit),
      .running  (running),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   assign tm = {min_tens, min_ones, sec_tens, sec_ones};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] bcd(input int s);
      int m;
      int x;
      m = s / 60;
      x = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   // Steps until a tick is seen; got stays 0 if the budget runs out.
   task automatic wait_tick(output bit got);
      got = 1'b0;
      for (int i = 0; i < 2 * SEC; i++) begin
         step();
         if (sec_tick === 1'b1) begin
            got = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      clr = 1'b1;
      step();
      clr = 1'b0;
      vectors++;
      if ({tm, sec_tick, running, overflow, an, digit} !== {16'h0000, 3'b000, 4'b1110, 4'h0}) begin
         miscompares++;
         $display("FAIL reset: got tm=%h tick=%b run=%b ovf=%b an=%b digit=%h", tm, sec_tick, running, overflow, an, digit);
      end
   endtask

   task automatic test_idle_scan();
      logic [3:0] exp_an;
      for (int k = 0; k < 50; k++) begin
         case ((k / SCAN) % 4)
            0: exp_an = 4'b1110;
            1: exp_an = 4'b1101;
            2: exp_an = 4'b1011;
            default: exp_an = 4'b0111;
         endcase
         vectors++;
         if ({an, digit, running, tm} !== {exp_an, 4'h0, 1'b0, 16'h0000}) begin
            miscompares++;
            $display("FAIL idle_scan k=%0d: got an=%b digit=%h run=%b tm=%h expected an=%b", k, an, digit, running, tm, exp_an);
         end
         step();
      end
   endtask

   // Leaves the DUT in RUN at prescaler 5 with time 00:12.
   task automatic test_run();
      int ticks;
      int bad;
      ticks = 0;
      bad   = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 125; c++) begin
         step();
         if (sec_tick === 1'b1) ticks++;
         if (sec_tick !== ((c % SEC) == 0)) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL run_tick_spacing: got %0d misplaced tick cycles, expected 0", bad);
      end
      vectors++;
      if (ticks != 12) begin
         miscompares++;
         $display("FAIL run_tick_count: got %0d expected 12", ticks);
      end
      vectors++;
      if ({sec_tens, sec_ones, running, min_tens, min_ones} !== {4'd1, 4'd2, 1'b1, 8'h00}) begin
         miscompares++;
         $display("FAIL run_time: got tm=%h run=%b expected 0012 run=1", tm, running);
      end
   endtask

   task automatic test_pause();
      int bad;
      for (int c = 126; c <= 134; c++) step();
      vectors++;
      if (tm !== 16'h0013) begin
         miscompares++;
         $display("FAIL pause_pre_time: got %h expected 0013", tm);
      end
      pause = 1'b1;
      step();
      pause = 1'b0;
      vectors++;
      if ({running, sec_tick} !== 2'b00) begin
         miscompares++;
         $display("FAIL pause_enter: got run=%b tick=%b expected 0 0", running, sec_tick);
      end
      bad = 0;
      for (int i = 0; i < 37; i++) begin
         step();
         if (sec_tick !== 1'b0 || tm !== 16'h0013 || running !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL pause_hold: got %0d bad cycles expected 0", bad);
      end
      pause = 1'b1;
      step();
      pause = 1'b0;
      bad = 0;
      for (int r = 1; r <= 6; r++) begin
         step();
         if (sec_tick !== (r == 6)) bad++;
      end
      vectors++;
      if (bad != 0 || tm !== 16'h0014 || running !== 1'b1) begin
         miscompares++;
         $display("FAIL pause_resume: got bad=%0d tm=%h run=%b expected tick at 6, 0014, run=1", bad, tm, running);
      end
   endtask

   task automatic test_saturate();
      bit got;
      int bad;
      stop = 1'b1;
      step();
      stop = 1'b0;
      vectors++;
      if ({tm, running} !== {16'h0000, 1'b0}) begin
         miscompares++;
         $display("FAIL stop_clear: got tm=%h run=%b expected 0000 0", tm, running);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 59; n++) begin
         wait_tick(got);
         if (!got) break;
      end
      vectors++;
      if (!got || tm !== 16'h0059) begin
         miscompares++;
         $display("FAIL preload_0059: got tm=%h tick=%b expected 0059", tm, got);
      end
      wait_tick(got);
      vectors++;
      if (!got || tm !== 16'h0100) begin
         miscompares++;
         $display("FAIL carry_0100: got tm=%h tick=%b expected 0100", tm, got);
      end
      for (int n = 61; n <= 5999; n++) begin
         wait_tick(got);
         vectors++;
         if (!got || tm !== bcd(n)) begin
            miscompares++;
            $display("FAIL count n=%0d: got tm=%h tick=%b expected %h", n, tm, got, bcd(n));
            break;
         end
      end
      wait_tick(got);
      vectors++;
      if (!got || {tm, overflow, running} !== {16'h9959, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL saturate: got tm=%h tick=%b ovf=%b run=%b expected 9959 1 1 0", tm, got, overflow, running);
      end
      bad = 0;
      for (int i = 0; i < 3 * SEC; i++) begin
         step();
         if (sec_tick !== 1'b0 || tm !== 16'h9959 || overflow !== 1'b1) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL sat_hold: got %0d bad cycles expected 0", bad);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      vectors++;
      if ({tm, overflow, running} !== {16'h0000, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL sat_stop: got tm=%h ovf=%b run=%b expected 0000 0 0", tm, overflow, running);
      end
   endtask

   task automatic test_simultaneous();
      bit got;
      int bad;
      start = 1'b1;
      pause = 1'b1;
      step();
      start = 1'b0;
      pause = 1'b0;
      vectors++;
      if (running !== 1'b1) begin
         miscompares++;
         $display("FAIL start_pause_idle: got run=%b expected 1", running);
      end
      wait_tick(got);
      vectors++;
      if (!got || tm !== 16'h0001) begin
         miscompares++;
         $display("FAIL start_pause_tick: got tm=%h tick=%b expected 0001", tm, got);
      end
      stop  = 1'b1;
      start = 1'b1;
      step();
      stop  = 1'b0;
      start = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         if (running !== 1'b0 || sec_tick !== 1'b0 || tm !== 16'h0000) bad++;
         step();
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL stop_start_run: got %0d bad cycles expected 0", bad);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (SEC - 1) step();
      pause = 1'b1;
      step();
      pause = 1'b0;
      vectors++;
      if ({sec_tick, running, tm} !== {1'b1, 1'b0, 16'h0001}) begin
         miscompares++;
         $display("FAIL pause_at_tc: got tick=%b run=%b tm=%h expected 1 0 0001", sec_tick, running, tm);
      end
      pause = 1'b1;
      step();
      pause = 1'b0;
      bad = 0;
      for (int r = 1; r <= SEC; r++) begin
         step();
         if (sec_tick !== (r == SEC)) bad++;
      end
      vectors++;
      if (bad != 0 || tm !== 16'h0002) begin
         miscompares++;
         $display("FAIL pause_at_tc_resume: got bad=%0d tm=%h expected 0 0002", bad, tm);
      end
   endtask

   task automatic test_clr_mid_run();
      bit got;
      int bad;
      logic [3:0] exp_d;
      stop = 1'b1;
      step();
      stop  = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int n = 1; n <= 207; n++) begin
         wait_tick(got);
         if (!got) break;
      end
      vectors++;
      if (!got || tm !== 16'h0327) begin
         miscompares++;
         $display("FAIL reach_0327: got tm=%h tick=%b expected 0327", tm, got);
      end
      pause = 1'b1;
      step();
      pause = 1'b0;
      bad = 0;
      for (int i = 0; i < 4 * SCAN; i++) begin
         step();
         case (an)
            4'b1110: exp_d = 4'd7;
            4'b1101: exp_d = 4'd2;
            4'b1011: exp_d = 4'd3;
            4'b0111: exp_d = 4'd0;
            default: exp_d = 4'hF;
         endcase
         if (exp_d === 4'hF || digit !== exp_d) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL scan_digit: got %0d bad an/digit pairs expected 0", bad);
      end
      pause = 1'b1;
      step();
      pause = 1'b0;
      repeat (3) step();
      @(negedge clk);
      clr = 1'b1;
      #2;
      clr = 1'b0;
      step();
      vectors++;
      if ({running, tm, overflow} !== {1'b1, 16'h0327, 1'b0}) begin
         miscompares++;
         $display("FAIL clr_glitch: got run=%b tm=%h ovf=%b expected 1 0327 0", running, tm, overflow);
      end
      clr = 1'b1;
      step();
      clr = 1'b0;
      vectors++;
      if ({tm, sec_tick, running, overflow, an, digit} !== {16'h0000, 3'b000, 4'b1110, 4'h0}) begin
         miscompares++;
         $display("FAIL clr_mid_run: got tm=%h tick=%b run=%b ovf=%b an=%b digit=%h", tm, sec_tick, running, overflow, an, digit);
      end
   endtask

   initial begin
      step();
      test_reset();
      test_idle_scan();
      test_run();
      test_pause();
      test_saturate();
      test_simultaneous();
      test_clr_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
